// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sram_pkg
// Purpose  : Shared types and the program image for the SRAM responder.
//            sram_state_t - INIT (array preload) / SERVE (bus requests honoured)
//            INIT_WORDS   - number of image words preloaded from address 0
//            INIT_IMAGE   - the image itself; element [k] lands at address k
// Revision : 1.0  initial release
// ============================================================================
package sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    SERVE = 1'b1
  } sram_state_t;

  localparam int INIT_WORDS = 3;
  // Bits needed to index the image.
  localparam int INIT_IDX_W = $clog2(INIT_WORDS);

  localparam logic [INIT_WORDS-1:0][15:0] INIT_IMAGE = {
    16'hFFFF,   // word 2
    16'h0420,   // word 1
    16'h0006    // word 0
  };

endpackage
`default_nettype wire

// File: rtl/sram_init_rom.sv
`default_nettype none
// ============================================================================
// Module   : sram_init_rom
// Purpose  : Combinational image lookup used while the array is preloaded.
//            Returns the image word for an index, or zero at/above INIT_WORDS.
// Ports    : index [ADDR_W-1:0] in  - array address being initialised
//            word  [15:0]       out - value to write at that address
// Revision : 1.0  initial release
// ============================================================================
module sram_init_rom
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] index,
  output logic [15:0]       word
);

  logic w_in_image;

  assign w_in_image = (index < ADDR_W'(INIT_WORDS));
  // The narrow select can reach past the image, but only when w_in_image is low.
  assign word = w_in_image ? INIT_IMAGE[index[INIT_IDX_W-1:0]] : 16'h0000;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Purpose  : Cycle-based model of a 16-bit asynchronous SRAM on the CPU bus.
//            After reset the whole array is rewritten (image then zeros), one
//            word per cycle; afterwards byte-lane reads and writes are served
//            synchronously to Clk.
// Ports    : Clk    in    system clock, rising edge
//            Reset  in    asynchronous, active-high
//            CE     in    chip enable, active-low
//            UB/LB  in    upper/lower byte lane enables, active-low
//            OE     in    output enable, active-low
//            WE     in    write enable, active-low (wins over OE)
//            ADDR   in    word address; bits above ADDR_W-1 alias
//            Data   inout driven only by a read response, else high-Z
//            Ready  out   high once the preload is complete
// Revision : 1.0  initial release
// ============================================================================
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        Ready
);

  sram_state_t       r_state;
  sram_state_t       w_state_nxt;
  logic              w_serving;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [15:0]       w_rom_word;
  logic [15:0]       r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_addr;
  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_drv_hi;
  logic              w_drv_lo;
  logic              w_unused;

  // Read pipeline: valid, captured word and the lane enables of the request.
  logic              r_pv  [READ_LAT];
  logic              r_pub [READ_LAT];
  logic              r_plb [READ_LAT];
  logic [15:0]       r_pd  [READ_LAT];

  sram_init_rom #(
    .ADDR_W (ADDR_W)
  ) u_init_rom (
    .index (r_init_cnt),
    .word  (w_rom_word)
  );

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_serving   = 1'b0;
    case (r_state)
      INIT:    if (r_init_cnt == '1) w_state_nxt = SERVE;
      SERVE:   w_serving = 1'b1;
      default: w_state_nxt = INIT;
    endcase
  end

  assign Ready = w_serving;

  // Walks every address once; it wraps to zero on the edge that enters SERVE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_init_cnt <= '0;
    end else if (r_state == INIT) begin
      r_init_cnt <= r_init_cnt + ADDR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Request decode and array
  // --------------------------------------------------------------------------
  assign w_addr   = ADDR[ADDR_W-1:0];
  assign w_unused = ^ADDR[19:ADDR_W];
  assign w_wr_req = w_serving & ~CE & ~WE;
  assign w_rd_req = w_serving & ~CE &  WE & ~OE;

  always_ff @(posedge Clk) begin
    if (r_state == INIT) begin
      r_mem[r_init_cnt] <= w_rom_word;
    end else if (w_wr_req) begin
      if (!UB) r_mem[w_addr][15:8] <= Data[15:8];
      if (!LB) r_mem[w_addr][7:0]  <= Data[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Read response pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pv[0]  <= 1'b0;
      r_pub[0] <= 1'b0;
      r_plb[0] <= 1'b0;
      r_pd[0]  <= 16'h0000;
    end else begin
      r_pv[0]  <= w_rd_req;
      r_pub[0] <= ~UB;
      r_plb[0] <= ~LB;
      r_pd[0]  <= r_mem[w_addr];
    end
  end

  for (genvar g = 1; g < READ_LAT; g++) begin : g_stage
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_pv[g]  <= 1'b0;
        r_pub[g] <= 1'b0;
        r_plb[g] <= 1'b0;
        r_pd[g]  <= 16'h0000;
      end else begin
        r_pv[g]  <= r_pv[g-1];
        r_pub[g] <= r_pub[g-1];
        r_plb[g] <= r_plb[g-1];
        r_pd[g]  <= r_pd[g-1];
      end
    end
  end

  // A draining response never fights a write the master is driving now.
  assign w_drv_hi = r_pv[READ_LAT-1] & r_pub[READ_LAT-1] & WE;
  assign w_drv_lo = r_pv[READ_LAT-1] & r_plb[READ_LAT-1] & WE;

  assign Data[15:8] = w_drv_hi ? r_pd[READ_LAT-1][15:8] : 8'bz;
  assign Data[7:0]  = w_drv_lo ? r_pd[READ_LAT-1][7:0]  : 8'bz;

endmodule
`default_nettype wire

// File: doc/sram_responder.md
# sram_responder

Cycle-based model of the external 16-bit asynchronous SRAM, the responder side of the CPU's memory bus (active-low CE/UB/LB/OE/WE, 20-bit ADDR, bidirectional Data). It sits in the simulation top level opposite the CPU's memory interface. After reset it preloads a program image, then serves byte-lane reads and writes synchronously to the system clock. This lets CPU tests run without a board.

## Interface
Parameters:
- ADDR_W, 10: implemented address bits; depth is 2^ADDR_W words.
- READ_LAT, 1: cycles from a read being sampled to Data being driven (1..3).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- CE  input  1  chip enable, active-low.
- UB  input  1  upper byte lane enable (Data[15:8]), active-low.
- LB  input  1  lower byte lane enable (Data[7:0]), active-low.
- OE  input  1  output enable, active-low.
- WE  input  1  write enable, active-low.
- ADDR  input  20  word address; bits above ADDR_W-1 are ignored, so addresses alias modulo depth.
- Data  inout  16  driven only during a read response; otherwise high-Z.
- Ready  output  1  high when initialisation is complete and bus requests are honoured.

## Operation
- FSM states:
  - INIT: a counter walks addresses 0..2^ADDR_W-1, writing one word per cycle. Words below INIT_WORDS come from the image; all others are written 0.
  - SERVE: entered the cycle after the last INIT write; remains there until reset.
- Request decode, sampled at each rising edge in SERVE:
  - write: CE=0 and WE=0. Each lane with its enable low is written from Data; a lane whose enable is high keeps its old value.
  - read: CE=0, WE=1, OE=0.
  - idle: all other combinations.
- WE=0 and OE=0 together is treated as a write. Data is not driven.
- UB=LB=1 with CE=0 is a no-op: no write occurs and nothing is driven.
- Read data comes from the array contents at the sample edge. A read in the cycle after a write to the same address returns the new value.
- Read response: a READ_LAT-deep valid/data pipeline.
  - Data lanes are driven when the pipeline output is valid and that lane's enable, sampled with the request, was low.
  - Undriven lanes are high-Z.
- Requests during INIT are ignored and Data stays high-Z.
- Reset asserted mid-operation:
  - Returns to INIT at address 0 and clears the read pipeline.
  - Ready drops immediately.
  - The array is fully rewritten, so prior writes are lost.

## Timing
- Reset values: Ready=0, Data high-Z, read pipeline invalid, init counter 0, state INIT.
- INIT lasts exactly 2^ADDR_W cycles after reset deasserts. Ready rises on the edge that enters SERVE.
- Write: takes effect at the sampling edge, with no added latency.
- Read sampled at edge N: Data is valid from just after edge N+READ_LAT-1 until edge N+READ_LAT. With READ_LAT=1 it is valid in the cycle following the sample.
- Back-to-back reads, one per cycle, are fully pipelined.
- Data is released to high-Z on the first edge where the pipeline output is invalid. There is no extra turnaround cycle.
- Read pipeline entries continue to drain if the bus switches to a write. Data is still suppressed whenever WE=0 is currently asserted, so that bus contention is avoided.

## Structure
- Package sram_pkg:
  - typedef sram_state_t {INIT, SERVE}.
  - Constants INIT_WORDS and INIT_IMAGE (array of 16-bit words). The test image is word0=16'h0006, word1=16'h0420, word2=16'hFFFF.
- Sub-module sram_init_rom: combinational lookup, index to image word, returning 0 at or beyond INIT_WORDS.
- The top level holds the FSM, init counter, array, read pipeline and tristate drivers.

## Test plan
- Reset pulse, ADDR_W=10 -> Ready=0 for exactly 1024 cycles, then Ready=1. Reads of addresses 0/1/2/3 return 16'h0006/16'h0420/16'hFFFF/16'h0000 one cycle after each sample.
- Write 16'hABCD to 5 with UB=LB=0. Then write 16'h1234 to 5 with UB=1, LB=0. Read 5 -> 16'hAB34.
- Read with LB=1, UB=0 at address 1 -> Data[15:8]=8'h04 and Data[7:0] high-Z. Idle cycle -> all 16 bits high-Z.
- WE=0 and OE=0 together, Data=16'h5555, ADDR=7 -> Data never driven by the responder. A later read of 7 returns 16'h5555. Write to ADDR=20'h00407 then read 7 -> the new value (aliasing).
- Reads issued during INIT -> no response and Data high-Z. Reset asserted 3 cycles after a write of 16'h7777 to 0 -> Ready drops at once, and after re-init address 0 reads 16'h0006.
- READ_LAT=3 with back-to-back reads of 0,1,2 -> responses 16'h0006, 16'h0420, 16'hFFFF on consecutive cycles, starting 3 cycles after the first sample.
